// File: rtl/uart_rx_status_fifo.sv
// uart_rx_status_fifo: receive character buffer between the UART RX core and the LSU/CSR read port.
// Each entry is stored as {frame_err, overrun_err, data}. A read produces registered rd_data plus a
// one-cycle rd_valid strobe. Status outputs: count, empty, full, almost_full, sticky overflow, err_pending.
// Ports: clk/reset (async, active-high); write side wr_en/wr_data/wr_frame_err/wr_overrun_err;
//        read side rd_en -> rd_data/rd_valid; control flush, clr_overflow; status count/empty/full/
//        almost_full/overflow/err_pending.
// DEPTH must be a power of two >= 2 and AF_LEVEL must lie in 1..DEPTH; neither is checked here.
module uart_rx_status_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_frame_err,
   input  logic                     wr_overrun_err,
   input  logic                     rd_en,
   input  logic                     flush,
   input  logic                     clr_overflow,
   output logic [DATA_W+1:0]        rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic                     overflow,
   output logic                     err_pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_W + 2;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] err_cnt;
   logic [EW-1:0] rd_entry;
   logic          rd_acc;
   logic          wr_acc;
   logic          wr_drop;
   logic          wr_tag;
   logic          rd_tag;

   assign empty       = (count == '0);
   assign full        = (count == CW'(DEPTH));
   assign almost_full = (count >= CW'(AF_LEVEL));
   assign err_pending = (err_cnt != '0);

   assign rd_entry = mem[rd_ptr];
   assign rd_tag   = rd_entry[EW-1] | rd_entry[EW-2];
   assign wr_tag   = wr_frame_err | wr_overrun_err;

   // A read on an empty buffer is ignored even if a write lands in the same cycle (no fall-through).
   // A write into a full buffer is accepted when a read frees a slot in the same cycle.
   assign rd_acc  = rd_en && !empty && !flush;
   assign wr_acc  = wr_en && (!full || rd_acc) && !flush;
   assign wr_drop = wr_en && full && !rd_acc && !flush;

   // Storage has no reset; after reset or flush the stale entries are unreachable via the pointers.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= {wr_frame_err, wr_overrun_err, wr_data};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         err_cnt  <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         overflow <= 1'b0;
      end else if (flush) begin
         // overflow and rd_data intentionally survive a flush
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         err_cnt  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) begin
            rd_data <= rd_entry;
            rd_ptr  <= rd_ptr + AW'(1);
         end
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end

         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase

         // Tagged entries in and out in the same cycle cancel out.
         case ({wr_acc && wr_tag, rd_acc && rd_tag})
            2'b10:   err_cnt <= err_cnt + CW'(1);
            2'b01:   err_cnt <= err_cnt - CW'(1);
            default: ;
         endcase

         // A drop in the same cycle as clr_overflow keeps the flag set.
         if (wr_drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_status_fifo.sv
// Testbench for uart_rx_status_fifo with default parameters (DATA_W 8, DEPTH 16, AF_LEVEL 12).
// Most checks come from a table of {inputs, expected outputs} vectors, applied one per clock.
// Hand-written sequences cover reset state and an asynchronous reset asserted mid-stream.
module tb_uart_rx_status_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_frame_err;
   logic       wr_overrun_err;
   logic       rd_en;
   logic       flush;
   logic       clr_overflow;
   logic [9:0] rd_data;
   logic       rd_valid;
   logic [4:0] count;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic       overflow;
   logic       err_pending;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic       w;
      logic [7:0] d;
      logic       fe;
      logic       oe;
      logic       r;
      logic       fl;
      logic       clr;
      logic       rv;
      logic [9:0] rdat;
      int         cnt;
      logic       ovf;
      logic       errp;
   } vec_t;

   vec_t       tbl[$];
   logic [9:0] last_rd = 10'h000;

   uart_rx_status_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_data(wr_data), .wr_frame_err(wr_frame_err), .wr_overrun_err(wr_overrun_err),
      .rd_en(rd_en), .flush(flush), .clr_overflow(clr_overflow),
      .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
      .almost_full(almost_full), .overflow(overflow), .err_pending(err_pending)
   );

   always #5 clk = ~clk;

   // Appends one vector; when no read completes, rd_data is expected to hold its last value.
   function automatic void add(logic w, logic [7:0] d, logic fe, logic oe, logic r, logic fl,
                               logic clr, logic rv, logic [9:0] rdat, int cnt, logic ovf, logic errp);
      vec_t v;
      v.w = w; v.d = d; v.fe = fe; v.oe = oe; v.r = r; v.fl = fl; v.clr = clr;
      v.rv = rv; v.cnt = cnt; v.ovf = ovf; v.errp = errp;
      if (rv) last_rd = rdat;
      v.rdat = last_rd;
      tbl.push_back(v);
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic chk_idle_state(string tag);
      chk({tag, " rd_valid"},    -1, rd_valid,    0);
      chk({tag, " rd_data"},     -1, rd_data,     0);
      chk({tag, " count"},       -1, count,       0);
      chk({tag, " empty"},       -1, empty,       1);
      chk({tag, " full"},        -1, full,        0);
      chk({tag, " almost_full"}, -1, almost_full, 0);
      chk({tag, " overflow"},    -1, overflow,    0);
      chk({tag, " err_pending"}, -1, err_pending, 0);
   endtask

   task automatic apply(vec_t v, int idx);
      wr_en = v.w; wr_data = v.d; wr_frame_err = v.fe; wr_overrun_err = v.oe;
      rd_en = v.r; flush = v.fl; clr_overflow = v.clr;
      @(posedge clk);
      #1;
      chk("rd_valid",    idx, rd_valid,    v.rv);
      chk("rd_data",     idx, rd_data,     v.rdat);
      chk("count",       idx, count,       v.cnt);
      chk("empty",       idx, empty,       v.cnt == 0);
      chk("full",        idx, full,        v.cnt == 16);
      chk("almost_full", idx, almost_full, v.cnt >= 12);
      chk("overflow",    idx, overflow,    v.ovf);
      chk("err_pending", idx, err_pending, v.errp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; wr_en = 0; wr_data = 0; wr_frame_err = 0; wr_overrun_err = 0;
      rd_en = 0; flush = 0; clr_overflow = 0;
      #3;
      chk_idle_state("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Fill to full, then drain in order; empty read afterwards yields nothing.
      for (int i = 0; i < 16; i++) add(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, i + 1, 0, 0);
      for (int j = 0; j < 16; j++) add(0, 0, 0, 0, 1, 0, 0, 1, 10'(j), 15 - j, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

      // Dropped write on full, clear overflow, then simultaneous read+write on full.
      for (int i = 0; i < 16; i++) add(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, i + 1, 0, 0);
      add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 16, 1, 0);
      add(0, 0, 0, 0, 1, 0, 0, 1, 10'h000, 15, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 15, 0, 0);
      add(1, 8'h10, 0, 0, 0, 0, 0, 0, 0, 16, 0, 0);
      add(1, 8'h55, 0, 0, 1, 0, 0, 1, 10'h001, 16, 0, 0);
      for (int j = 0; j < 16; j++)
         add(0, 0, 0, 0, 1, 0, 0, 1, (j < 14) ? 10'(j + 2) : ((j == 14) ? 10'h010 : 10'h055),
             15 - j, 0, 0);

      // Error tags and err_pending tracking, including same-cycle cancel.
      add(1, 8'h41, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      add(1, 8'h42, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
      add(0, 0, 0, 0, 1, 0, 0, 1, 10'h241, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 1, 10'h042, 0, 0, 0);
      add(1, 8'h43, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
      add(0, 0, 0, 0, 1, 0, 0, 1, 10'h143, 0, 0, 0);
      add(1, 8'h44, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      add(1, 8'h45, 0, 1, 1, 0, 0, 1, 10'h244, 1, 0, 1);
      add(0, 0, 0, 0, 1, 0, 0, 1, 10'h145, 0, 0, 0);

      // Interleaved traffic wraps both pointers several times.
      for (int k = 0; k < 40; k++) begin
         add(1, 8'(8'h60 + k), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
         add(0, 0, 0, 0, 1, 0, 0, 1, 10'(10'h060 + k), 0, 0, 0);
      end
      // Read on empty with a same-cycle write: write lands, no fall-through.
      add(1, 8'h33, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 1, 10'h033, 0, 0, 0);

      // Flush with 5 entries (one tagged) and concurrent wr_en/rd_en.
      for (int i = 0; i < 5; i++) add(1, 8'(8'hB0 + i), i == 2, 0, 0, 0, 0, 0, 0, i + 1, 0, i >= 2);
      add(1, 8'hCC, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 1, 10'h077, 0, 0, 0);

      // Overflow survives flush; set wins over clr_overflow in the same cycle.
      for (int i = 0; i < 16; i++) add(1, 8'(8'hD0 + i), 0, 0, 0, 0, 0, 0, 0, i + 1, 0, 0);
      add(1, 8'hEE, 0, 0, 0, 0, 0, 0, 0, 16, 1, 0);
      add(1, 8'hEF, 0, 0, 0, 0, 1, 0, 0, 16, 1, 0);
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
      add(1, 8'h41, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      add(1, 8'h42, 1, 0, 0, 0, 0, 0, 0, 2, 1, 1);
      add(0, 0, 0, 0, 1, 0, 0, 1, 10'h241, 1, 1, 1);

      foreach (tbl[i]) apply(tbl[i], i);

      // Asynchronous reset mid-stream: all outputs return without a clock edge.
      wr_en = 0; rd_en = 0; flush = 0; clr_overflow = 0; wr_frame_err = 0; wr_overrun_err = 0;
      #1;
      reset = 1'b1;
      #1;
      chk_idle_state("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_idle_state("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_status_fifo.md
# uart_rx_status_fifo

Parametrised receive buffer for the UART RX path: stores each received character together with its frame-error and overrun-error tags. The UART RX core writes into it; the LSU/CSR read interface drains it. Compared with the fixed 16x10 buffer it generalises width and depth, and adds:

- true simultaneous read/write;
- a registered read port with a valid strobe;
- almost-full, sticky overflow and error-pending status;
- a synchronous flush.

## Interface

Parameters:
- DATA_W, default 8: character width in bits. Each entry is DATA_W+2 bits.
- DEPTH, default 16: number of entries. Must be a power of two, at least 2.
- AF_LEVEL, default 12: almost_full asserts when count >= AF_LEVEL. Legal range 1..DEPTH.

Ports (reset reset, asynchronous, active-high; clock clk):
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- wr_en, in, 1: write request from the RX core.
- wr_data, in, DATA_W: received character.
- wr_frame_err, in, 1: frame-error tag for this character.
- wr_overrun_err, in, 1: overrun-error tag for this character.
- rd_en, in, 1: read (pop) request.
- flush, in, 1: synchronous clear of all contents.
- clr_overflow, in, 1: clears the sticky overflow flag.
- rd_data, out, DATA_W+2: popped entry, packed as {frame_err, overrun_err, data}.
- rd_valid, out, 1: one-cycle strobe; rd_data was updated this cycle.
- count, out, $clog2(DEPTH)+1: current number of stored entries, 0..DEPTH.
- empty, out, 1: count == 0.
- full, out, 1: count == DEPTH.
- almost_full, out, 1: count >= AF_LEVEL.
- overflow, out, 1: sticky flag; a write was dropped.
- err_pending, out, 1: at least one stored entry carries an error tag.

## Operation

- Storage: DEPTH-entry array. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- count, overflow, rd_data, rd_valid and the internal error counter are registers. empty, full, almost_full and err_pending decode combinationally from registers.
- Read accepted: rd_en && !empty.
  - On the clock edge: rd_data <= mem[rd_ptr], rd_ptr += 1, rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its previous value.
- Write accepted: wr_en && (!full || read accepted this cycle).
  - On the clock edge: mem[wr_ptr] <= {wr_frame_err, wr_overrun_err, wr_data}, wr_ptr += 1.
- Write dropped: wr_en && full && no read accepted. The entry is discarded, overflow <= 1, and pointers and count are unchanged.
- count update:
  - +1 for a write only;
  - -1 for a read only;
  - unchanged when both are accepted or neither is.
- Error counter (err_cnt, same width as count):
  - +1 on an accepted write with either tag set;
  - -1 on an accepted read whose entry has either tag set;
  - both in the same cycle cancel.
  - err_pending = (err_cnt != 0).
- Overflow flag:
  - clr_overflow clears it.
  - If clr_overflow and a dropped write occur in the same cycle, set wins: overflow = 1.
- Flush:
  - Highest priority after reset. Pointers, count and err_cnt go to 0; rd_valid <= 0.
  - wr_en and rd_en are ignored that cycle.
  - overflow and rd_data are unchanged.
- Empty read: rd_en while empty is ignored. No underflow state and no pointer change. This applies even when a write arrives in the same cycle; there is no fall-through.

## Timing

- Reset values (asynchronous): pointers 0, count 0, err_cnt 0, rd_data 0, rd_valid 0, overflow 0. Therefore empty = 1, full = 0, almost_full = 0, err_pending = 0.
- Reset mid-operation takes effect immediately and does not wait for a clock edge. Memory contents are not cleared and are unreachable afterwards.
- Write latency: a write at edge N is reflected in count, empty and almost_full after edge N. The entry is readable by an rd_en sampled at edge N+1.
- Read latency: rd_en sampled at edge N gives rd_data and rd_valid valid after edge N, for exactly one cycle of rd_valid.
- Back-to-back reads on every cycle sustain one entry per cycle.
- Full with simultaneous rd_en and wr_en: both are accepted, count stays at DEPTH, and overflow is not set.
- Pointer wrap from DEPTH-1 to 0 requires no special handling. count distinguishes full from empty.

## Test plan

- Reset then 16 writes (0x00..0x0F, no errors, default parameters) → count = 16, full = 1, almost_full = 1 from the 12th write. Then 16 reads → rd_data = 0x000..0x00F in order, one rd_valid per read, empty = 1 at the end.
- Full FIFO plus a write of 0xAA alone → entry dropped, overflow = 1, count = 16. Next read returns 0x000. clr_overflow → overflow = 0.
- Full FIFO with rd_en and wr_en (0x55) in the same cycle → count stays 16, overflow = 0. 0x055 is returned as the 16th subsequent read.
- Write 0x41 with frame_err = 1, then 0x42 clean → rd_data = 0x241 with err_pending = 1 until that read completes, then 0x042 with err_pending = 0.
- 40 writes interleaved with 40 reads (pointer wrap) → data stays in order, count never exceeds 1. rd_en while empty produces no rd_valid.
- Load 5 entries, then assert flush together with wr_en → count = 0, empty = 1, write ignored. Assert reset mid-stream → all outputs return to reset values asynchronously.
